// File: rtl/sdram_pattern_tester.sv
// SDRAM exerciser: writes an indexed pattern burst into WR1 and serves key-triggered reads on RD_CH FIFOs.
// Define PT_CHECK_EN to build the read-data comparator (err_cnt / err_flag); otherwise both are tied to 0.
module sdram_pattern_tester #(
    parameter int          DATA_W = 8,
    parameter int          LEN    = 256,
    parameter int          RD_CH  = 2,
    parameter int          SETTLE = 4,
    parameter logic [31:0] SEED   = 32'hA5
) (
    input  logic                    REF_CLK,
    input  logic                    RESET_N,
    input  logic                    start_n,
    input  logic [RD_CH-1:0]        rd_req_n,
    input  logic [1:0]              mode,
    output logic                    wr_en,
    output logic [DATA_W-1:0]       wr_data,
    output logic                    wr_load,
    output logic                    rd_load,
    output logic [RD_CH-1:0]        rd_en,
    input  logic [RD_CH*DATA_W-1:0] rd_data,
    output logic [RD_CH*DATA_W-1:0] disp,
    output logic                    busy,
    output logic [15:0]             err_cnt,
    output logic                    err_flag
);
    localparam int IW = (LEN > 1) ? $clog2(LEN) : 1;
    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_SETTLE, ST_READY} state_t;

    state_t            state_reg, state_next;
    logic [1:0]        mode_reg;
    logic [IW-1:0]     widx_reg;
    logic [SW-1:0]     settle_cnt_reg;
    logic              wr_load_reg;
    logic              start_s0_reg, start_s1_reg;
    logic              start_edge, start_go;
    logic [RD_CH-1:0]  rd_s0_reg, rd_s1_reg, rd_en_reg;

    function automatic logic [DATA_W-1:0] pattern(input logic [1:0] m, input logic [IW-1:0] idx);
        logic [DATA_W-1:0] iv;
        logic [DATA_W-1:0] alt;
        iv = DATA_W'(idx);
        for (int b = 0; b < DATA_W; b++) begin
            alt[b] = b[0] ~^ idx[0];
        end
        case (m)
            2'd0:    return iv;
            2'd1:    return ~iv;
            2'd2:    return iv ^ DATA_W'(SEED);
            default: return alt;
        endcase
    endfunction

    assign start_edge = start_s1_reg & ~start_s0_reg;
    assign start_go   = start_edge && (state_reg == ST_IDLE || state_reg == ST_READY);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE, ST_READY: if (start_edge) state_next = ST_WRITE;
            ST_WRITE:  if (!wr_load_reg && widx_reg == IW'(LEN - 1)) state_next = ST_SETTLE;
            ST_SETTLE: if (settle_cnt_reg == SW'(SETTLE - 1)) state_next = ST_READY;
            default:   state_next = ST_IDLE;
        endcase
    end

    // The wr_load cycle lives inside WRITE; writes begin once the pulse has gone.
    assign wr_en   = (state_reg == ST_WRITE) && !wr_load_reg;
    assign wr_data = pattern(mode_reg, widx_reg);
    assign wr_load = wr_load_reg;
    assign busy    = (state_reg == ST_WRITE) || (state_reg == ST_SETTLE);
    assign rd_load = (state_reg != ST_READY);
    assign rd_en   = rd_en_reg;

    always_ff @(posedge REF_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_reg      <= ST_IDLE;
            mode_reg       <= 2'd0;
            widx_reg       <= '0;
            settle_cnt_reg <= '0;
            wr_load_reg    <= 1'b0;
            start_s0_reg   <= 1'b1;
            start_s1_reg   <= 1'b1;
        end else begin
            state_reg    <= state_next;
            start_s0_reg <= start_n;
            start_s1_reg <= start_s0_reg;
            wr_load_reg  <= start_go;
            if (start_go) begin
                mode_reg <= mode;
                widx_reg <= '0;
            end else if (wr_en) begin
                widx_reg <= widx_reg + 1'b1;
            end
            settle_cnt_reg <= (state_reg == ST_SETTLE) ? settle_cnt_reg + 1'b1 : '0;
        end
    end

`ifdef PT_CHECK_EN
    logic [IW-1:0]    rd_idx_reg [RD_CH];
    logic [RD_CH-1:0] mismatch;
    logic [2:0]       mis_count;
    logic [16:0]      err_sum;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < RD_CH; gi++) begin : g_ch
            always_ff @(posedge REF_CLK or negedge RESET_N) begin
                if (!RESET_N) begin
                    rd_s0_reg[gi]                  <= 1'b1;
                    rd_s1_reg[gi]                  <= 1'b1;
                    rd_en_reg[gi]                  <= 1'b0;
                    disp[gi*DATA_W +: DATA_W]      <= '0;
                end else begin
                    rd_s0_reg[gi] <= rd_req_n[gi];
                    rd_s1_reg[gi] <= rd_s0_reg[gi];
                    rd_en_reg[gi] <= rd_s1_reg[gi] & ~rd_s0_reg[gi] & (state_reg == ST_READY);
                    if (rd_en_reg[gi]) disp[gi*DATA_W +: DATA_W] <= rd_data[gi*DATA_W +: DATA_W];
                end
            end
`ifdef PT_CHECK_EN
            localparam logic [IW-1:0] BASE = IW'(gi * (LEN / RD_CH));
            // Each channel reads back its own contiguous slice of the burst.
            always_ff @(posedge REF_CLK or negedge RESET_N) begin
                if (!RESET_N)          rd_idx_reg[gi] <= BASE;
                else if (start_go)     rd_idx_reg[gi] <= BASE;
                else if (rd_en_reg[gi]) rd_idx_reg[gi] <= rd_idx_reg[gi] + 1'b1;
            end
            assign mismatch[gi] = rd_en_reg[gi] &&
                (rd_data[gi*DATA_W +: DATA_W] != pattern(mode_reg, rd_idx_reg[gi]));
`endif
        end
    endgenerate

`ifdef PT_CHECK_EN
    always_comb begin
        mis_count = '0;
        for (int c = 0; c < RD_CH; c++) mis_count = mis_count + 3'(mismatch[c]);
        err_sum = {1'b0, err_cnt} + 17'(mis_count);
    end

    always_ff @(posedge REF_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            err_cnt  <= 16'd0;
            err_flag <= 1'b0;
        end else begin
            if (start_go)     err_cnt <= 16'd0;
            else if (err_sum[16]) err_cnt <= 16'hFFFF;
            else              err_cnt <= err_sum[15:0];
            if (mis_count != 3'd0) err_flag <= 1'b1;
        end
    end
`else
    assign err_cnt  = 16'd0;
    assign err_flag = 1'b0;
`endif
endmodule

// File: tb/tb_sdram_pattern_tester.sv
// Directed + randomized bench for sdram_pattern_tester with a behavioural pattern/FIFO model.
module tb_sdram_pattern_tester;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_n;
    logic [1:0]  rd_req_n;
    logic [1:0]  mode;
    logic        wr_en, wr_load, rd_load, busy, err_flag;
    logic [7:0]  wr_data;
    logic [1:0]  rd_en;
    logic [15:0] rd_data, disp, err_cnt;
    logic [7:0]  rd_word [2];

    int total = 0;
    int bad   = 0;
`ifdef PT_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    int         cur_mode;
    int         next_idx [2];
    int         exp_err;
    bit         exp_flag;
    logic [7:0] exp_disp [2];

    assign rd_data = {rd_word[1], rd_word[0]};

    sdram_pattern_tester dut (
        .REF_CLK(clk), .RESET_N(rst_n), .start_n(start_n), .rd_req_n(rd_req_n), .mode(mode),
        .wr_en(wr_en), .wr_data(wr_data), .wr_load(wr_load), .rd_load(rd_load), .rd_en(rd_en),
        .rd_data(rd_data), .disp(disp), .busy(busy), .err_cnt(err_cnt), .err_flag(err_flag)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] pattern_ref(input int m, input int i);
        int v;
        case (m)
            0:       v = i;
            1:       v = 255 - (i % 256);
            2:       v = i ^ 'hA5;
            default: v = (i % 2 == 0) ? 'h55 : 'hAA;
        endcase
        return 8'(v % 256);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_start(input int m);
        cur_mode    = m;
        next_idx[0] = 0;
        next_idx[1] = 128;
        exp_err     = 0;
    endtask

    // Full burst with per-cycle checks; reset_at >= 0 aborts the burst by reset at that word.
    task automatic burst(input int m, input int reset_at, input bit inject);
        @(negedge clk);
        mode = 2'(m); start_n = 1'b0;
        @(negedge clk);
        check("pre_load", {30'd0, wr_load, wr_en}, 0);
        start_n = 1'b1;
        @(negedge clk);
        model_start(m);
        check("wr_load", wr_load, 1);
        check("wr_en_in_load", wr_en, 0);
        check("busy_load", busy, 1);
        check("err_clr", err_cnt, 0);
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            if (i == reset_at) begin
                rst_n = 1'b0;
                #1;
                check("rst_wr_en", wr_en, 0);
                check("rst_rd_load", rd_load, 1);
                check("rst_busy", busy, 0);
                check("rst_disp", disp, 0);
                check("rst_err", {15'd0, err_flag, err_cnt}, 0);
                exp_err = 0; exp_flag = 1'b0; exp_disp[0] = 8'h00; exp_disp[1] = 8'h00;
                @(negedge clk);
                rst_n = 1'b1;
                mode  = 2'(m);
                return;
            end
            check($sformatf("wr_en_%0d", i), wr_en, 1);
            check($sformatf("wr_data_%0d", i), wr_data, pattern_ref(m, i));
            check("rd_en_in_write", rd_en, 0);
            if (i == 10) mode = 2'((m + 1) % 4);
            if (inject && i == 50) begin start_n = 1'b0; rd_req_n = 2'b00; end
            if (inject && i == 52) begin start_n = 1'b1; rd_req_n = 2'b11; end
        end
        for (int s = 0; s < 4; s++) begin
            @(negedge clk);
            check("settle_wr_en", wr_en, 0);
            check("settle_busy", busy, 1);
            check("settle_rd_load", rd_load, 1);
        end
        @(negedge clk);
        check("ready_busy", busy, 0);
        check("ready_rd_load", rd_load, 0);
    endtask

    task automatic do_read(input logic [1:0] mask, input logic [7:0] corr0, input logic [7:0] corr1);
        logic [7:0] corr [2];
        corr[0] = corr0; corr[1] = corr1;
        @(negedge clk);
        rd_req_n = ~mask;
        @(negedge clk);
        check("rd_en_early", rd_en, 0);
        rd_req_n = 2'b11;
        @(negedge clk);
        check("rd_en_pulse", rd_en, mask);
        for (int c = 0; c < 2; c++) begin
            if (mask[c]) begin
                rd_word[c]  = pattern_ref(cur_mode, next_idx[c]) ^ corr[c];
                exp_disp[c] = rd_word[c];
                if (CHK && corr[c] != 8'h00) begin
                    exp_flag = 1'b1;
                    if (exp_err < 65535) exp_err++;
                end
                next_idx[c] = (next_idx[c] + 1) % 256;
            end
        end
        @(negedge clk);
        check("rd_en_after", rd_en, 0);
        check("disp", disp, {exp_disp[1], exp_disp[0]});
        check("err_cnt", err_cnt, exp_err);
        check("err_flag", err_flag, exp_flag);
    endtask

    initial begin
        logic [7:0] mode1_seq [3];
        mode1_seq[0] = 8'hFF; mode1_seq[1] = 8'hFE; mode1_seq[2] = 8'hFD;
        rst_n = 1'b0; start_n = 1'b1; rd_req_n = 2'b11; mode = 2'd0;
        rd_word[0] = 8'h00; rd_word[1] = 8'h00;
        exp_err = 0; exp_flag = 1'b0; exp_disp[0] = 8'h00; exp_disp[1] = 8'h00;
        model_start(0);
        repeat (3) @(negedge clk);
        check("reset_outs", {wr_en, wr_load, rd_en, busy, err_flag}, 0);
        check("reset_rd_load", rd_load, 1);
        check("reset_disp", disp, 0);
        check("reset_err_cnt", err_cnt, 0);
        rst_n = 1'b1;

        // Read before any burst must be dropped.
        @(negedge clk); rd_req_n = 2'b01;
        @(negedge clk); rd_req_n = 2'b11;
        repeat (2) begin @(negedge clk); check("idle_rd_en", rd_en, 0); end

        burst(0, -1, 1'b0);

        burst(1, -1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            do_read(2'b01, 8'h00, 8'h00);
            check("mode1_disp0", disp[7:0], mode1_seq[k]);
        end

        burst(2, -1, 1'b0);
        do_read(2'b10, 8'h00, 8'h01);
        check("mode2_ch1_word", disp[15:8], 8'h24);
        do_read(2'b11, 8'hFF, 8'hFF);

        for (int k = 0; k < 8; k++) begin
            do_read(2'($urandom_range(1, 3)),
                    ($urandom_range(0, 1) == 1) ? 8'($urandom_range(1, 255)) : 8'h00,
                    ($urandom_range(0, 1) == 1) ? 8'($urandom_range(1, 255)) : 8'h00);
        end

        burst($urandom_range(0, 3), -1, 1'b1);
        do_read(2'b11, 8'h00, 8'h00);
        do_read(2'b11, 8'h00, 8'h10);

        burst($urandom_range(0, 3), 100, 1'b0);
        burst(3, -1, 1'b0);
        do_read(2'b11, 8'h00, 8'h00);

`ifdef PT_CHECK_EN
        @(negedge clk);
        force dut.err_cnt = 16'hFFFE;
        #1;
        release dut.err_cnt;
        exp_err = 65534;
        do_read(2'b11, 8'h01, 8'h02);
        do_read(2'b11, 8'h04, 8'h08);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sdram_pattern_tester.md
Name: sdram_pattern_tester

Overview:
- Parametrised SDRAM exerciser that sits between board keys and the Sdram_Control FIFO ports.
- Writes a selectable, index-addressable pattern burst into write FIFO 1.
- Serves key-triggered single-word reads on RD_CH read FIFOs and latches each word for the 7-segment display.
- Optionally checks every read word against its expected value and counts mismatches.
- Successor to the fixed 8-bit counter / two-reader test top, generalised in width, length, channel count and pattern mode.

Parameters:
- DATA_W, 8: width of the write data and of each read channel.
- LEN, 256: words per write burst; must be a power of two, 2..65536.
- RD_CH, 2: number of read channels, 1..4. LEN must be divisible by RD_CH.
- SETTLE, 4: cycles rd_load stays high after the burst ends.
- SEED, 8'hA5: XOR seed for mode 2, truncated or zero-extended to DATA_W.

Ports:
- REF_CLK  in  1  sole clock.
- RESET_N  in  1  asynchronous, active-low reset.
- start_n  in  1  raw key level; a falling edge starts a burst.
- rd_req_n  in  RD_CH  raw key levels; a falling edge on bit c requests one word on channel c.
- mode  in  2  pattern select, sampled when a burst starts.
- wr_en  out  1  write strobe to WR1.
- wr_data  out  DATA_W  write data to WR1_DATA.
- wr_load  out  1  one-cycle pulse to WR1_LOAD at burst start.
- rd_load  out  1  to every RDn_LOAD.
- rd_en  out  RD_CH  one-cycle read strobes, channel c on bit c.
- rd_data  in  RD_CH*DATA_W  FIFO read data; channel c occupies bits [c*DATA_W +: DATA_W].
- disp  out  RD_CH*DATA_W  latched read words, same packing as rd_data.
- busy  out  1  high while in WRITE or SETTLE.
- err_cnt  out  16  saturating mismatch count.
- err_flag  out  1  sticky; set when any mismatch is seen.

Behaviour:
- Reset (RESET_N low, asynchronous):
  - state returns to IDLE.
  - wr_en, wr_load, rd_en, disp, err_cnt, err_flag and busy all go to 0.
  - rd_load goes to 1.
  - Edge-detect chains reset to all-ones.
  - Reset is valid mid-burst: the burst is abandoned and no further writes are issued.
- Edge detection: each key passes through a two-flop chain (s0 <= key, s1 <= s0); edge = s1 & ~s0. Keys are assumed debounced externally.
- Pattern p(i), where i is the word index truncated to DATA_W:
  - mode 0: i
  - mode 1: ~i
  - mode 2: i ^ SEED
  - mode 3: 0x55.. when i is even, 0xAA.. when i is odd (pattern replicated to DATA_W)
- FSM states: IDLE, WRITE, SETTLE, READY.
- IDLE or READY, start edge:
  - Go to WRITE and latch mode.
  - Pulse wr_load for one cycle.
  - Clear widx.
  - Set rd_idx[c] = c*(LEN/RD_CH) for every channel.
- WRITE:
  - wr_en = 1 and wr_data = p(widx) for exactly LEN consecutive cycles, widx = 0..LEN-1.
  - The first wr_en cycle immediately follows the wr_load pulse.
  - Then go to SETTLE.
  - Start edges are ignored while in WRITE.
- SETTLE: lasts SETTLE cycles, then go to READY.
- rd_load = 1 in IDLE, WRITE and SETTLE; rd_load = 0 in READY.
- READY, rd_req edge on channel c:
  - rd_en[c] is high for exactly one cycle, the cycle after the edge is detected.
  - In the following cycle: disp[c] <= rd_data[c], compare rd_data[c] against p(rd_idx[c]), then rd_idx[c] increments modulo LEN.
  - Read requests outside READY are dropped: no rd_en and no index change.
- Multiple channels may fire in the same cycle and are handled independently.
- err_cnt adds the number of mismatching channels in that cycle and saturates at 16'hFFFF.
- err_flag is cleared only by reset. err_cnt is also cleared on each start.
- Latency: wr_en rises 2 clocks after the first REF_CLK edge that samples start_n low.

Optional Feature:
- PT_CHECK_EN defined: comparator, err_cnt and err_flag behave as described above.
- PT_CHECK_EN undefined: the comparator logic is removed; err_cnt and err_flag are tied to 0. Display capture is unchanged.

Test Plan:
1. Reset, then a start_n falling edge with mode=0, LEN=256 -> wr_load pulses once, then wr_en is high for exactly 256 cycles with wr_data 0x00..0xFF; busy drops 4 cycles after the last write; rd_load falls with busy.
2. Mode 1 burst followed by 3 channel-0 requests, with a behavioural FIFO model returning correct data -> disp[0] shows 0xFF, 0xFE, 0xFD; err_cnt = 0.
3. RD_CH=2, first channel-1 request -> expected index 128, mode 2 data = 0x80^0xA5 = 0x25. Model injects 0x24 -> err_cnt = 1, err_flag = 1.
4. Channel-0 and channel-1 edges in the same cycle, both data words corrupted -> err_cnt increments by 2 in a single cycle. Separately, with err_cnt preloaded near 16'hFFFF, further mismatches -> err_cnt saturates at 16'hFFFF.
5. Read request during WRITE -> no rd_en. Start edge during WRITE -> ignored, burst length stays 256.
6. RESET_N pulled low at word 100 of a burst -> wr_en drops immediately, rd_load = 1, state is IDLE; the next start restarts from index 0.
